// File: rtl/fb_write_ctrl_pkg.sv
// fb_defs: constants and types shared by the framebuffer write controller
// and the display stage.
//   H_RES / V_RES  : visible resolution; H_RES is also the address stride
//   FB_WORDS       : number of RAM words in one frame
//   FB_ADDR_W      : RAM word-address width
//   *_LSB / CH_W   : BGR555 field positions {b[4:0], g[4:0], r[4:0]}
//   wr_state_e     : write-controller FSM states
//   wr_beat_t      : one queued pixel write {y, x, data}
//   fb_addr()      : y*H_RES + x for H_RES = 240 using shifts only
package fb_defs;

  localparam int H_RES     = 240;
  localparam int V_RES     = 160;
  localparam int FB_WORDS  = H_RES * V_RES;
  localparam int FB_ADDR_W = 16;

  localparam int CH_W  = 5;
  localparam int R_LSB = 0;
  localparam int G_LSB = 5;
  localparam int B_LSB = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FILL  = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [7:0]  y;
    logic [7:0]  x;
    logic [14:0] data;
  } wr_beat_t;

  // 240*y == 256*y - 16*y; all terms fit in 16 bits for y <= 255.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [7:0] y,
                                                   input logic [7:0] x);
    logic [FB_ADDR_W-1:0] yw;
    logic [FB_ADDR_W-1:0] xw;
    yw = {8'b0, y};
    xw = {8'b0, x};
    return (yw << 8) - (yw << 4) + xw;
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: small synchronous FIFO holding queued pixel writes.
//   clk, clrn   : clock and synchronous active-low reset (empties the queue)
//   push, din   : write side; ignored when full unless a pop happens too
//   pop, dout   : read side; dout is the head entry (valid while !empty)
//   full, empty : occupancy flags
module fb_wr_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Pointers are AW bits wide, so they wrap modulo DEPTH by themselves.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl: owns the write port of the 240x160 BGR555 framebuffer RAM.
//   clk, clrn              : clock and synchronous active-low reset
//   wr_valid/wr_ready      : pixel write handshake, with wr_x, wr_y, wr_data
//   fill_start, fill_color : request a full-frame clear to fill_color
//   busy                   : a fill is pending (draining queue) or running
//   fill_done              : one-cycle pulse after the last fill word
//   drop                   : sticky flag, an out-of-range write was discarded
//   mem_we/addr/wdata      : registered RAM write port
module fb_write_ctrl
  import fb_defs::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [7:0]           wr_x,
  input  logic [7:0]           wr_y,
  input  logic [14:0]          wr_data,
  input  logic                 fill_start,
  input  logic [14:0]          fill_color,
  output logic                 busy,
  output logic                 fill_done,
  output logic                 drop,
  output logic                 mem_we,
  output logic [FB_ADDR_W-1:0] mem_addr,
  output logic [15:0]          mem_wdata
);

  localparam logic [7:0]           X_LIM     = 8'(H_RES);
  localparam logic [7:0]           Y_LIM     = 8'(V_RES);
  localparam logic [FB_ADDR_W-1:0] FILL_LAST = FB_ADDR_W'(FB_WORDS - 1);

  wr_state_e            state_q, state_d;
  logic [FB_ADDR_W-1:0] cnt_q, cnt_d;
  logic [14:0]          color_q, color_d;
  logic                 mem_we_q, mem_we_d;
  logic [FB_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]          mem_wdata_q, mem_wdata_d;
  logic                 drop_q, drop_d;
  logic                 last_q, last_d;
  logic                 fill_done_q, fill_done_d;

  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [$bits(wr_beat_t)-1:0] fifo_dout;
  wr_beat_t             head;
  logic                 in_range;

  assign wr_ready  = !fifo_full && (state_q == ST_IDLE) && clrn;
  assign fifo_push = wr_valid && wr_ready;
  // The queue keeps draining in IDLE and DRAIN; FILL owns the RAM port.
  assign fifo_pop  = !fifo_empty && (state_q != ST_FILL);
  assign head      = wr_beat_t'(fifo_dout);
  assign in_range  = (head.x < X_LIM) && (head.y < Y_LIM);

  fb_wr_fifo #(
    .WIDTH ($bits(wr_beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (fifo_push),
    .din   ({wr_y, wr_x, wr_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stage p0: pop/range check or fill word selection; next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    color_d     = color_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    drop_d      = drop_q;
    last_d      = 1'b0;
    fill_done_d = last_q;

    if (fifo_pop) begin
      if (in_range) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = fb_addr(head.y, head.x);
        mem_wdata_d = {1'b0, head.data};
      end else begin
        drop_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          color_d = fill_color;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          cnt_d   = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = cnt_q;
        mem_wdata_d = {1'b0, color_q};
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == FILL_LAST) begin
          state_d = ST_IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p1: registered RAM port and status.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      drop_q      <= 1'b0;
      last_q      <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      drop_q      <= drop_d;
      last_q      <= last_d;
      fill_done_q <= fill_done_d;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q   <= cnt_d;
    color_q <= color_d;
  end

  assign busy      = (state_q != ST_IDLE);
  assign fill_done = fill_done_q;
  assign drop      = drop_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// tb_fb_write_ctrl: self-checking bench for fb_write_ctrl. A reference model
// keeps the ordered list of RAM writes the frame buffer should receive
// (address y*240+x, or 0..38399 for a fill) and a monitor compares every
// observed write against it.
module tb_fb_write_ctrl;

  localparam int HR = 240;
  localparam int VR = 160;
  localparam int FB_WORDS = HR * VR;

  logic        clk = 1'b0;
  logic        clrn;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_x, wr_y;
  logic [14:0] wr_data;
  logic        fill_start;
  logic [14:0] fill_color;
  logic        busy, fill_done, drop, mem_we;
  logic [15:0] mem_addr, mem_wdata;

  fb_write_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .fill_start (fill_start),
    .fill_color (fill_color),
    .busy       (busy),
    .fill_done  (fill_done),
    .drop       (drop),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected RAM writes in order: {is_fill, addr[15:0], wdata[15:0]}.
  logic [32:0] expq[$];
  int  fill_wr_cnt = 0;
  int  fill_gap    = 0;
  int  fd_seen     = 0;
  bit  model_fill  = 0;
  bit  exp_drop    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic record_beat(input int x, input int y, input logic [14:0] d);
    if (x < HR && y < VR) expq.push_back({1'b0, 16'(y * HR + x), 1'b0, d});
    else exp_drop = 1'b1;
  endtask

  task automatic record_fill(input logic [14:0] c);
    if (!model_fill) begin
      model_fill = 1'b1;
      for (int i = 0; i < FB_WORDS; i++) expq.push_back({1'b1, 16'(i), 1'b0, c});
    end
  endtask

  // Monitor: every RAM write must be the next expected one.
  always @(negedge clk) begin
    logic [32:0] e;
    if (fill_done) fd_seen++;
    if (mem_we) begin
      if (expq.size() == 0) chk("spurious_we", mem_we, 1'b0);
      else begin
        e = expq.pop_front();
        chk("wr_addr_data", {mem_addr, mem_wdata}, e[31:0]);
        if (e[32]) begin
          fill_wr_cnt++;
          if (fill_wr_cnt == FB_WORDS) model_fill = 1'b0;
        end
      end
    end else if (fill_wr_cnt > 0 && fill_wr_cnt < FB_WORDS) begin
      fill_gap++;
    end
  end

  // Present one beat (optionally with fill_start in the same cycle) and hold
  // it until accepted. Called and returns at posedge+1.
  task automatic send(input int x, input int y, input logic [14:0] d,
                      input logic fs, input logic [14:0] fc);
    int  n = 0;
    bit  done = 0;
    wr_valid = 1'b1; wr_x = 8'(x); wr_y = 8'(y); wr_data = d;
    fill_start = fs; fill_color = fc;
    while (!done) begin
      @(negedge clk);
      if (wr_ready) begin
        record_beat(x, y, d);
        done = 1;
      end
      if (fill_start) record_fill(fc);
      if (!done && n >= 100) begin
        chk("wr_accept_timeout", wr_ready, 1'b1);
        done = 1;
      end
      tick();
      fill_start = 1'b0;
      n++;
    end
    wr_valid = 1'b0;
  endtask

  task automatic pulse_fill(input logic [14:0] c);
    fill_start = 1'b1; fill_color = c;
    @(negedge clk);
    record_fill(c);
    tick();
    fill_start = 1'b0;
  endtask

  initial begin
    int n;
    clrn = 1'b0; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    fill_start = 1'b0; fill_color = '0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fill_done", fill_done, 1'b0);
    chk("rst_drop", drop, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    tick();
    clrn = 1'b1;
    tick();

    // Test 1: reset mid-fill aborts it
    pulse_fill(15'h1234);
    n = 0;
    while (fill_wr_cnt < 1000 && n < 3000) begin @(negedge clk); n++; end
    chk("t1_fill_progress", fill_wr_cnt >= 1000, 1'b1);
    tick();
    clrn = 1'b0;
    tick();
    @(negedge clk);
    chk("t1_mem_we", mem_we, 1'b0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_fill_done", fill_done, 1'b0);
    chk("t1_wr_ready", wr_ready, 1'b0);
    expq.delete();
    fill_wr_cnt = 0; fill_gap = 0; model_fill = 1'b0;
    tick();
    clrn = 1'b1;
    repeat (3) tick();
    chk("t1_no_fill_done", fd_seen, 0);
    chk("t1_busy_after", busy, 1'b0);

    // Test 2: single write, latency N+2
    wr_valid = 1'b1; wr_x = 8'd5; wr_y = 8'd2; wr_data = 15'h7C00;
    @(negedge clk);
    chk("t2_wr_ready", wr_ready, 1'b1);
    record_beat(5, 2, 15'h7C00);
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("t2_we_n1", mem_we, 1'b0);
    @(negedge clk);
    chk("t2_we_n2", mem_we, 1'b1);
    chk("t2_addr", mem_addr, 16'd485);
    chk("t2_wdata", mem_wdata, 16'h7C00);
    tick();
    repeat (2) tick();

    // Test 3: burst of 6 back-to-back writes, no gaps once flowing
    fork
      begin
        for (int i = 0; i < 6; i++) send(10 + i, 20 + i, 15'(i * 1111 + 7), 1'b0, 15'h0);
      end
      begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk("t3_burst_we", mem_we, 1'b1);
        end
      end
    join
    tick();
    repeat (3) tick();
    chk("t3_all_written", expq.size(), 0);

    // Test 4: out-of-range writes are dropped, drop is sticky
    chk("t4_drop_pre", drop, 1'b0);
    send(240, 0, 15'h1111, 1'b0, 15'h0);
    send(0, 160, 15'h2222, 1'b0, 15'h0);
    repeat (4) tick();
    chk("t4_drop_set", drop, 1'b1);
    send(239, 159, 15'h3333, 1'b0, 15'h0);
    repeat (4) tick();
    chk("t4_drop_sticky", drop, 1'b1);
    chk("t4_all_written", expq.size(), 0);

    // Test 5/6: 3 queued writes, fill with the 3rd, ignored fill_start in FILL
    send(1, 1, 15'h0AAA, 1'b0, 15'h0);
    send(2, 1, 15'h0BBB, 1'b0, 15'h0);
    send(3, 1, 15'h0CCC, 1'b1, 15'h001F);
    @(negedge clk);
    chk("t5_busy", busy, 1'b1);
    chk("t5_wr_ready_low", wr_ready, 1'b0);
    tick();
    repeat (500) tick();
    pulse_fill(15'h7FFF);
    wr_valid = 1'b1; wr_x = 8'd7; wr_y = 8'd7; wr_data = 15'h5555;
    @(negedge clk);
    chk("t6_wr_ready_fill", wr_ready, 1'b0);
    chk("t6_busy_fill", busy, 1'b1);
    tick();
    wr_valid = 1'b0;
    n = 0;
    while (!fill_done && n < 40000) begin @(negedge clk); n++; end
    chk("t5_fill_done", fill_done, 1'b1);
    chk("t5_busy_at_done", busy, 1'b0);
    chk("t5_fill_writes_left", expq.size(), 0);
    chk("t5_fill_count", fill_wr_cnt, FB_WORDS);
    chk("t5_fill_gaps", fill_gap, 0);
    @(negedge clk);
    chk("t5_fill_done_pulse", fill_done, 1'b0);
    chk("t5_busy_next", busy, 1'b0);
    @(posedge clk); #1;
    repeat (3) tick();

    // Randomized traffic, including some out-of-range coordinates
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send($urandom_range(0, 250), $urandom_range(0, 165), 15'($urandom), 1'b0, 15'h0);
    end
    repeat (5) tick();
    chk("rnd_all_written", expq.size(), 0);
    chk("rnd_drop", drop, exp_drop);
    chk("fill_done_total", fd_seen, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
